vector_mem_responder: RTL and testbench
=======================================

Name: vector_mem_responder

Overview:
- Memory-side responder for the vector CPU's M-stage load/store interface. Sits between the datapath and a byte-wide data RAM that it owns internally.
- Accepts one vector request (R lanes of N bits) through a valid/ready handshake.
- Serialises the request into R single-byte RAM accesses, assembles load data, and returns a one-cycle response pulse with the assembled vector or error status.

Parameters:
I, 32, address width of request (matches AddressM)
N, 8, lane width in bits (RAM word width)
R, 6, lanes per vector access
DEPTH, 1024, RAM size in N-bit bytes
AW, 10, internal RAM address width (log2 DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
MemReqM  in  1  request valid
MemWriteM  in  1  1 = store, 0 = load (sampled with MemReqM)
AddressM  in  I  byte base address; lane k accesses AddressM+k
WriteDataM  in  R x N  store data, packed lanes [R-1:0][N-1:0]
ReqReady  out  1  responder can accept a request
ReadData  out  R x N  assembled load data, packed lanes
RspValid  out  1  one-cycle response pulse
RspWrite  out  1  response belongs to a store
AddrErr  out  1  response is an out-of-range error

Behaviour:
- Reset (async, reset=0): state IDLE, lane counter 0. ReqReady=1 after release; RspValid=0, RspWrite=0, AddrErr=0, ReadData=0. RAM contents are not cleared.
- Accept: on a rising edge with state IDLE, ReqReady=1 and MemReqM=1.
  - Latch AddressM[AW-1:0], the range check result, MemWriteM and WriteDataM.
  - Inputs may change freely afterwards.
- ReqReady=1 only in IDLE. Requests in any other state are ignored, with no queueing.
- Range check at accept: error if AddressM + R > DEPTH, evaluated with I+1-bit arithmetic so carry is not lost.
  - On error: next state RESP with AddrErr=1. No RAM write occurs; ReadData is unchanged.
- States: IDLE, WRITE, READ, RESP.
- WRITE (cnt 0..R-1):
  - Each edge writes lane cnt to RAM[addr+cnt] and increments cnt.
  - On the edge with cnt=R-1, go to RESP.
  - RspValid rises R edges after the accept edge (6 for R=6).
- READ (cnt 0..R):
  - RAM read is synchronous, 1-cycle latency.
  - In cycle cnt (cnt<R), present RAM address addr+cnt.
  - On each edge with cnt>=1, capture RAM output into lane cnt-1 of the load buffer.
  - On the edge with cnt=R, go to RESP.
  - RspValid rises R+1 edges after accept (7 for R=6).
- RESP (exactly one cycle): RspValid=1, RspWrite=latched write flag, AddrErr per range check. Next edge returns to IDLE.
- ReadData:
  - Updated from the load buffer only on entry to RESP for a successful load.
  - Held stable otherwise, including through stores and errors, until the next successful load.
  - Lanes are never visible half-updated.
- No back-pressure on the response; the consumer must sample in the RspValid cycle.
- Addresses are unaligned-legal; there is no wrap-around (the range error covers overflow).
- Reset mid-operation: immediate return to IDLE, outputs cleared. RAM lanes already written stay written; unwritten lanes keep their old values. No response is issued.
- Store then load to the same address: the load observes all R stored bytes, because the store fully completes before ReqReady returns.

Test Plan:
1. Store at 16, lanes 0x11,0x22,0x33,0x44,0x55,0x66 (lane0=0x11) -> ReqReady low 7 cycles; RspValid pulse 6 edges after accept with RspWrite=1, AddrErr=0. Then load at 16 -> RspValid 7 edges after accept, ReadData lanes = 0x11..0x66, RspWrite=0.
2. Unaligned load at 19 after test 1 -> lanes 0x44,0x55,0x66 then the three bytes at 22..24 (written beforehand 0xA0,0xA1,0xA2).
3. Boundary: store at 1018 succeeds (AddrErr=0, bytes 1018..1023 written). Load at 1019 -> RspValid one edge after accept with AddrErr=1; ReadData keeps its previous value.
4. Hold MemReqM=1 with varying AddressM during a busy store -> only the first request takes effect; exactly one RspValid pulse; ReqReady returns to 1 the cycle after RESP.
5. Reset asserted after 3 WRITE edges of a 0xFF-filled store at 32 (prior RAM 0x00) -> outputs zero immediately, no RspValid. A later load at 32 returns FF,FF,FF,00,00,00.
6. Address 0xFFFF_FFFE -> AddrErr=1, no RAM modification; the I+1-bit add catches the overflow.

Source files
------------

// File: rtl/vector_mem_responder.sv
// Memory-side responder: accepts one R-lane vector load/store and serialises it into
// byte-wide accesses on an internal synchronous RAM, then issues a one-cycle response.
module vector_mem_responder #(
  parameter int unsigned I     = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned R     = 6,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReqM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddressM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic                ReqReady,
  output logic [R-1:0][N-1:0] ReadData,
  output logic                RspValid,
  output logic                RspWrite,
  output logic                AddrErr
);

  localparam int unsigned CW = $clog2(R + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q;
  logic                wr_q, err_q;
  logic [R-1:0][N-1:0] wdata_q;
  logic [R-1:0][N-1:0] lbuf_q, lbuf_d;
  logic [R-1:0][N-1:0] rdata_q, rdata_d;

  logic [N-1:0]        mem [DEPTH];
  logic [N-1:0]        ram_rdata;
  logic [AW-1:0]       ram_addr;
  logic [I:0]          end_addr;
  logic                range_err;
  logic                accept;

  // One extra bit keeps the carry so addresses near 2^I cannot wrap into range.
  assign end_addr  = {1'b0, AddressM} + (I+1)'(R);
  assign range_err = end_addr > (I+1)'(DEPTH);
  assign accept    = (state_q == StIdle) && MemReqM;
  assign ram_addr  = addr_q + AW'(cnt_q);

  always_ff @(posedge clk) begin
    if (state_q == StWrite) begin
      mem[ram_addr] <= wdata_q[cnt_q];
    end
    ram_rdata <= mem[ram_addr];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lbuf_d  = lbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (MemReqM) begin
          cnt_d = '0;
          if (range_err)      state_d = StResp;
          else if (MemWriteM) state_d = StWrite;
          else                state_d = StRead;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(R - 1)) state_d = StResp;
      end
      StRead: begin
        // RAM output lags the presented address by one cycle.
        if (cnt_q != '0) lbuf_d[cnt_q - CW'(1)] = ram_rdata;
        if (cnt_q == CW'(R)) begin
          state_d = StResp;
          rdata_d = lbuf_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      lbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lbuf_q  <= lbuf_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= AddressM[AW-1:0];
        wr_q    <= MemWriteM;
        err_q   <= range_err;
        wdata_q <= WriteDataM;
      end
    end
  end

  assign ReqReady = (state_q == StIdle);
  assign RspValid = (state_q == StResp);
  assign RspWrite = RspValid & wr_q;
  assign AddrErr  = RspValid & err_q;
  assign ReadData = rdata_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Scoreboard bench for vector_mem_responder: directed requests push expected responses,
// a negedge monitor pops and compares each RspValid pulse.
module tb_vector_mem_responder;

  logic            clk;
  logic            reset;
  logic            MemReqM;
  logic            MemWriteM;
  logic [31:0]     AddressM;
  logic [5:0][7:0] WriteDataM;
  logic            ReqReady;
  logic [5:0][7:0] ReadData;
  logic            RspValid;
  logic            RspWrite;
  logic            AddrErr;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [47:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [47:0] last_rd = '0;

  vector_mem_responder #(
    .I(32), .N(8), .R(6), .DEPTH(1024), .AW(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .AddressM   (AddressM),
    .WriteDataM (WriteDataM),
    .ReqReady   (ReqReady),
    .ReadData   (ReadData),
    .RspValid   (RspValid),
    .RspWrite   (RspWrite),
    .AddrErr    (AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && RspValid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got RspValid=1 expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_wr_err_data", {14'd0, RspWrite, AddrErr, ReadData}, {14'd0, e.wr, e.err, e.data});
      end
    end
  end

  // For loads, d is the expected ReadData; for stores it is the write data.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [47:0] d,
                       input bit exp_err, input int exp_lat, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    check("ready_before", {63'd0, ReqReady}, 64'd1);
    MemReqM    = 1'b1;
    MemWriteM  = wr;
    AddressM   = a;
    WriteDataM = d;
    if (!wr && !exp_err) last_rd = d;
    e.wr   = wr;
    e.err  = exp_err;
    e.data = last_rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) begin
      MemReqM    = 1'b0;
      AddressM   = 32'hDEAD_BEEF;
      WriteDataM = '1;
    end
    n = 0;
    while (!RspValid && n < 20) begin
      if (hold) AddressM = AddressM + 32'd37;
      @(posedge clk);
      #1;
      n++;
    end
    MemReqM = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    check("ready_in_resp", {63'd0, ReqReady}, 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_resp", {63'd0, ReqReady}, 64'd1);
    check("single_pulse", {63'd0, RspValid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemReqM = 1'b0;
    MemWriteM = 1'b0;
    AddressM = '0;
    WriteDataM = '0;
    #1;
    check("reset_outs", {59'd0, RspValid, RspWrite, AddrErr, 1'b0, 1'b0}, 64'd0);
    check("reset_rdata", {16'd0, ReadData}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, ReqReady}, 64'd1);

    // Test 1: store then load at 16
    issue(1'b1, 32'd16, 48'h665544332211, 1'b0, 6, 1'b0);
    issue(1'b0, 32'd16, 48'h665544332211, 1'b0, 7, 1'b0);
    // Test 2: bytes 22..27, then unaligned load at 19
    issue(1'b1, 32'd22, 48'hA5A4A3A2A1A0, 1'b0, 6, 1'b0);
    issue(1'b0, 32'd19, 48'hA2A1A0665544, 1'b0, 7, 1'b0);
    // Test 3: boundary store succeeds, one past fails with ReadData held
    issue(1'b1, 32'd1018, 48'hC6C5C4C3C2C1, 1'b0, 6, 1'b0);
    issue(1'b0, 32'd1019, 48'h0, 1'b1, 0, 1'b0);
    // Test 6: overflowing address must not write 1022 (its low AW bits)
    issue(1'b1, 32'hFFFF_FFFE, 48'hEEEEEEEEEEEE, 1'b1, 0, 1'b0);
    issue(1'b0, 32'd1018, 48'hC6C5C4C3C2C1, 1'b0, 7, 1'b0);
    // Test 4: request held with shifting address during busy store
    issue(1'b1, 32'd100, 48'h060504030201, 1'b0, 6, 1'b1);
    issue(1'b0, 32'd100, 48'h060504030201, 1'b0, 7, 1'b0);

    // Test 5: reset after three WRITE edges of an FF-filled store at 32
    issue(1'b1, 32'd32, 48'h000000000000, 1'b0, 6, 1'b0);
    @(negedge clk);
    MemReqM = 1'b1;
    MemWriteM = 1'b1;
    AddressM = 32'd32;
    WriteDataM = '1;
    @(posedge clk);
    #1;
    MemReqM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_outs", {61'd0, RspValid, RspWrite, AddrErr}, 64'd0);
    check("midreset_rdata", {16'd0, ReadData}, 64'd0);
    check("midreset_ready", {63'd0, ReqReady}, 64'd1);
    last_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    issue(1'b0, 32'd32, 48'h000000FFFFFF, 1'b0, 7, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
